// File: rtl/vm_coin_pkg.sv
// rtl/vm_coin_pkg.sv - shared types and defaults for the coin acceptor front-end
package vm_coin_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        DEBOUNCE     = 3'd1,
        EMIT         = 3'd2,
        REJECT       = 3'd3,
        WAIT_RELEASE = 3'd4
    } state_t;

    typedef enum logic {
        COIN_5  = 1'b0,
        COIN_10 = 1'b1
    } coin_t;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_JAM_CYCLES      = 1024;
    localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/coin_sync.sv
// rtl/coin_sync.sv - two-flop synchroniser for one asynchronous sensor line
module coin_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    // Two back-to-back flops; only r_q is safe to use in the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - debounces coin sensors, classifies coins, flags jams, keeps audit counts
module coin_acceptor
    import vm_coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int JAM_CYCLES      = DEF_JAM_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             coin5_raw,
    input  logic             coin10_raw,
    input  logic             enable,
    input  logic             clr_counts,
    output logic             five_coin,
    output logic             ten_coin,
    output logic             coin_reject,
    output logic             jam,
    output logic [CNT_W-1:0] count5,
    output logic [CNT_W-1:0] count10
);

    localparam int CW = $clog2(JAM_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] JAM_LAST = CW'(JAM_CYCLES - 1);
    localparam logic [CW-1:0] JAM_MAX  = CW'(JAM_CYCLES);

    logic w_s5;
    logic w_s10;
    logic w_line;
    logic w_other;
    logic w_any;
    logic w_deb_done;
    logic w_emit5;
    logic w_emit10;

    state_t         r_state;
    coin_t          r_type;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  r_rcnt;
    logic [CW-1:0]  r_hcnt;
    logic           r_five;
    logic           r_ten;
    logic           r_rej;
    logic           r_jam;
    logic [CNT_W-1:0] r_count5;
    logic [CNT_W-1:0] r_count10;

    coin_sync u_sync5 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (coin5_raw),
        .o_q   (w_s5)
    );

    coin_sync u_sync10 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (coin10_raw),
        .o_q   (w_s10)
    );

    // The latched coin type selects which synced line is "ours" and which is the intruder.
    assign w_line     = (r_type == COIN_10) ? w_s10 : w_s5;
    assign w_other    = (r_type == COIN_10) ? w_s5  : w_s10;
    assign w_any      = w_s5 | w_s10;
    assign w_deb_done = (r_state == DEBOUNCE) && w_line && !w_other && (r_cnt == DEB_LAST);
    assign w_emit5    = w_deb_done && (r_type == COIN_5);
    assign w_emit10   = w_deb_done && (r_type == COIN_10);

    // Main FSM: pulses are set on the transition into EMIT/REJECT so they are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_type  <= COIN_5;
            r_cnt   <= '0;
            r_rcnt  <= '0;
            r_hcnt  <= '0;
            r_five  <= 1'b0;
            r_ten   <= 1'b0;
            r_rej   <= 1'b0;
            r_jam   <= 1'b0;
        end else begin
            r_five <= 1'b0;
            r_ten  <= 1'b0;
            r_rej  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_s5 && w_s10) begin
                        r_state <= REJECT;
                        r_rej   <= 1'b1;
                    end else if (w_any) begin
                        if (enable) begin
                            r_state <= DEBOUNCE;
                            r_type  <= w_s10 ? COIN_10 : COIN_5;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= REJECT;
                            r_rej   <= 1'b1;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (w_other) begin
                        r_state <= REJECT;
                        r_rej   <= 1'b1;
                    end else if (!w_line) begin
                        r_state <= IDLE;
                    end else if (w_deb_done) begin
                        r_state <= EMIT;
                        r_five  <= w_emit5;
                        r_ten   <= w_emit10;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                EMIT, REJECT: begin
                    r_state <= WAIT_RELEASE;
                    r_rcnt  <= '0;
                end
                WAIT_RELEASE: begin
                    if (w_any) begin
                        r_rcnt <= '0;
                        if (r_hcnt != JAM_MAX) begin
                            r_hcnt <= r_hcnt + 1'b1;
                        end
                        if (r_hcnt == JAM_LAST) begin
                            r_jam <= 1'b1;
                        end
                    end else if (r_rcnt == DEB_LAST) begin
                        r_state <= IDLE;
                        r_jam   <= 1'b0;
                        r_hcnt  <= '0;
                    end else begin
                        r_rcnt <= r_rcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Saturating audit counters; a clear on the same cycle as an accept wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count5  <= '0;
            r_count10 <= '0;
        end else if (clr_counts) begin
            r_count5  <= '0;
            r_count10 <= '0;
        end else begin
            if (w_emit5 && (r_count5 != {CNT_W{1'b1}})) begin
                r_count5 <= r_count5 + 1'b1;
            end
            if (w_emit10 && (r_count10 != {CNT_W{1'b1}})) begin
                r_count10 <= r_count10 + 1'b1;
            end
        end
    end

    assign five_coin   = r_five;
    assign ten_coin    = r_ten;
    assign coin_reject = r_rej;
    assign jam         = r_jam;
    assign count5      = r_count5;
    assign count10     = r_count10;

endmodule
